nibble_add_tester: RTL and testbench
====================================

NIBBLE_ADD_TESTER -- requirements
Module: nibble_add_tester

Interface
REQ-001 Parameter LATENCY, default 1: number of clock cycles the adder under test needs between operands being presented and its result being valid; legal range 1..15.
REQ-002 The block SHALL have the following ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset; asynchronous, active-high.
- start  input  1  level-sampled request to run the full vector sweep.
- op_a  output  4  operand A presented to the adder (drives ui_in[7:4] of the adder).
- op_b  output  4  operand B presented to the adder (drives ui_in[3:0] of the adder).
- result_in  input  4  sum returned by the adder (from uo_out[3:0] of the adder).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high while in DONE.
- pass  output  1  high in DONE when err_count==0.
- err_count  output  8  number of mismatching vectors, saturating.
- fail_info  output  12  {first failing vector index[7:0], received value[3:0]}.

Function
REQ-003 The state machine SHALL have states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-004 The vector index SHALL be an 8-bit counter idx, so a sweep covers 256 vectors; op_a SHALL equal idx[7:4] and op_b SHALL equal idx[3:0].
REQ-005 In IDLE, start=1 at a rising edge SHALL clear idx, err_count and fail_info and move the FSM to DRIVE.
REQ-006 DRIVE SHALL last 1 cycle and then move to WAIT.
REQ-007 WAIT SHALL last exactly LATENCY cycles, counted by a 4-bit counter, and then move to CHECK.
REQ-008 CHECK SHALL last 1 cycle and SHALL compare result_in with the expected value (op_a+op_b) mod 16, which is the 5-bit sum truncated to 4 bits.
REQ-009 On a mismatch in CHECK, err_count SHALL increment, saturating at 255; this limit is reachable, since all 256 vectors failing yields 255.
REQ-010 At the end of CHECK, if idx!=255 then idx SHALL increment and the FSM SHALL move to DRIVE; if idx==255 the FSM SHALL move to DONE and idx SHALL NOT wrap.
REQ-011 op_a and op_b SHALL be held stable through DRIVE, WAIT and CHECK of each vector; each vector therefore takes LATENCY+2 cycles and a full sweep takes 256*(LATENCY+2) cycles.
REQ-012 busy SHALL be 1 in DRIVE, WAIT and CHECK, and 0 otherwise.
REQ-013 done SHALL be 1 only in DONE; pass SHALL equal done AND (err_count==0).
REQ-014 start SHALL be ignored in DRIVE, WAIT and CHECK.
REQ-015 In DONE, start=1 at a rising edge SHALL restart the sweep exactly as REQ-005; with start=0 the FSM SHALL remain in DONE, holding all results.
REQ-016 In IDLE and DONE, op_a and op_b SHALL be 0.

Reset
REQ-017 While reset=1, the FSM SHALL be in IDLE, asynchronously.
REQ-018 While reset=1, idx, the WAIT counter, err_count and fail_info SHALL be 0.
REQ-019 While reset=1, busy, done and pass SHALL be 0, and op_a and op_b SHALL be 0.
REQ-020 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained; after reset deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-021 Macro TESTER_FIRST_FAIL_EN, when defined, SHALL enable first-failure capture: on the first mismatch of a sweep, fail_info SHALL be loaded with {idx, result_in}; later mismatches SHALL NOT change fail_info until the next sweep start.
REQ-022 When TESTER_FIRST_FAIL_EN is undefined, fail_info SHALL be constant 0 and no capture registers SHALL be built.

Verification
REQ-023 Scenario: LATENCY=1, correct registered-adder model, one-cycle start pulse from IDLE -> done=1 and pass=1 after 768 rising edges following the start-sampling edge; err_count=0 and busy=0 in DONE.
REQ-024 Scenario: adder model with result_in stuck at 0 -> err_count=240 (the 16 vectors with (a+b) mod 16 == 0 pass) and pass=0; with TESTER_FIRST_FAIL_EN, fail_info=12'h010 (index 1, received 0).
REQ-025 Scenario: adder model returning the inverted sum (~(a+b)) -> all 256 vectors fail and err_count saturates at 255; with TESTER_FIRST_FAIL_EN, fail_info=12'h00F.
REQ-026 Scenario: LATENCY=3 with a 3-cycle-delay correct adder model -> pass=1 after 1280 cycles; the same model run with LATENCY=1 -> err_count!=0.
REQ-027 Scenario: reset pulsed at cycle 100 of a sweep -> all outputs are 0 immediately, the FSM is in IDLE after deassertion, and a new start produces a full clean sweep.
REQ-028 Scenario: start held high continuously -> mid-sweep start has no effect, and a new sweep begins on the edge after DONE is first entered, with done high for exactly 1 cycle.

Source files
------------

// File: rtl/nibble_add_tester.sv
// nibble_add_tester: sweeps all 256 {a,b} nibble pairs through an external
// 4-bit adder, waits LATENCY cycles per vector and checks the returned sum
// against (a+b) mod 16, counting mismatches with saturation at 255.
//
// Optional feature macro: TESTER_FIRST_FAIL_EN
//   defined   -> fail_info captures {idx, result_in} of the first mismatch
//   undefined -> fail_info is constant 0 and no capture register is built
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   level-sampled sweep request (honoured in IDLE and DONE)
//   op_a       out  operand A = idx[7:4] while busy, else 0
//   op_b       out  operand B = idx[3:0] while busy, else 0
//   result_in  in   sum returned by the adder under test
//   busy       out  sweep in progress (DRIVE/WAIT/CHECK)
//   done       out  sweep finished (DONE)
//   pass       out  done and no mismatches
//   err_count  out  saturating mismatch count
//   fail_info  out  {first failing index, received value}
module nibble_add_tester #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  input  logic [3:0]  result_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [11:0] fail_info
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned ERR_W  = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(255);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(255);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [3:0]          op_a_q, op_a_d;
  logic [3:0]          op_b_q, op_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [4:0]          sum_full;
  logic                mismatch;
`ifdef TESTER_FIRST_FAIL_EN
  logic [11:0]         fail_q, fail_d;
`endif

  // Expected sum is the 5-bit sum of the current operands truncated to 4 bits
  assign sum_full = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0]};
  assign mismatch = (result_in != sum_full[3:0]);

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
`ifdef TESTER_FIRST_FAIL_EN
    fail_d  = fail_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          wait_d  = '0;
          err_d   = '0;
`ifdef TESTER_FIRST_FAIL_EN
          fail_d  = '0;
`endif
        end
      end
      S_DRIVE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
`ifdef TESTER_FIRST_FAIL_EN
          // err_q==0 marks the first mismatch of this sweep
          if (err_q == '0) begin
            fail_d = {idx_q, result_in};
          end
`endif
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they align with state_q
    busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
    op_a_d = busy_d ? idx_d[7:4] : 4'h0;
    op_b_d = busy_d ? idx_d[3:0] : 4'h0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef TESTER_FIRST_FAIL_EN
  // First-failure capture register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end
  assign fail_info = fail_q;
`else
  assign fail_info = 12'h000;
`endif

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_nibble_add_tester.sv
// Testbench for nibble_add_tester: two instances (LATENCY=1 and LATENCY=3)
// driven by selectable adder models; a cycle model of the sweep checks the
// LATENCY=1 instance on every negedge, plus literal end-of-sweep checks.
module tb_nibble_add_tester;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  mode;

  logic [3:0]  op_a1, op_b1, result1;
  logic        busy1, done1, pass1;
  logic [7:0]  err1;
  logic [11:0] fail1;

  logic [3:0]  op_a3, op_b3, result3;
  logic        busy3, done3, pass3;
  logic [7:0]  err3;
  logic [11:0] fail3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_add_tester #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .op_a(op_a1), .op_b(op_b1), .result_in(result1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_info(fail1)
  );

  nibble_add_tester #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .op_a(op_a3), .op_b(op_b3), .result_in(result3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_info(fail3)
  );

  // Adder models: mode 0 registered, 1 stuck-at-0, 2 inverted, 3 three-stage pipe
  logic [4:0] sum1, sum3;
  logic [3:0] r1 = 4'h0, s1 = 4'h0, s2 = 4'h0, s3 = 4'h0;
  logic [3:0] p1 = 4'h0, p2 = 4'h0, p3 = 4'h0;
  assign sum1 = {1'b0, op_a1} + {1'b0, op_b1};
  assign sum3 = {1'b0, op_a3} + {1'b0, op_b3};

  always @(posedge clk) begin
    r1 <= sum1[3:0];
    s1 <= sum1[3:0];
    s2 <= s1;
    s3 <= s2;
    p1 <= sum3[3:0];
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    case (mode)
      2'd0:    result1 = r1;
      2'd1:    result1 = 4'h0;
      2'd2:    result1 = ~r1;
      default: result1 = s3;
    endcase
  end
  assign result3 = p3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep model for dut1: each vector is DRIVE + LATENCY waits + CHECK
  localparam int L1 = 1;
  bit m_run = 0, m_done = 0;
  int m_idx = 0, m_ph = 0, m_err = 0, m_fail = 0;

  always @(negedge clk) begin
    int res, expv;
    if (reset) begin
      m_run = 0; m_done = 0; m_idx = 0; m_ph = 0; m_err = 0; m_fail = 0;
    end
    chk("busy",  32'(busy1),  32'(m_run));
    chk("done",  32'(done1),  32'(m_done));
    chk("pass",  32'(pass1),  32'(m_done && m_err == 0));
    chk("op_a",  32'(op_a1),  m_run ? 32'(m_idx / 16) : 32'd0);
    chk("op_b",  32'(op_b1),  m_run ? 32'(m_idx % 16) : 32'd0);
    chk("err",   32'(err1),   32'(m_err));
    chk("fail",  32'(fail1),  32'(m_fail));
    if (!reset) begin
      if (!m_run) begin
        if (start1) begin
          m_run = 1; m_done = 0; m_idx = 0; m_ph = 0; m_err = 0; m_fail = 0;
        end
      end else if (m_ph == L1 + 1) begin
        res  = int'(result1);
        expv = (m_idx / 16 + m_idx % 16) % 16;
        if (res != expv) begin
`ifdef TESTER_FIRST_FAIL_EN
          if (m_err == 0) m_fail = m_idx * 16 + res;
`endif
          if (m_err < 255) m_err++;
        end
        m_ph = 0;
        if (m_idx == 255) begin
          m_run = 0; m_done = 1;
        end else begin
          m_idx++;
        end
      end else begin
        m_ph++;
      end
    end
  end

  // Pulse start1 for one cycle and check done rises exactly 768 edges later
  task automatic sweep1(input string name);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (767) @(posedge clk);
    #1 chk({name, "_done_early"}, 32'(done1), 32'd0);
    @(posedge clk);
    #1 chk({name, "_done_768"}, 32'(done1), 32'd1);
    chk({name, "_busy_done"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_err",  32'(err1),  32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    reset = 1'b0;

    // Correct registered adder
    sweep1("ok");
    chk("ok_pass", 32'(pass1), 32'd1);
    chk("ok_err",  32'(err1),  32'd0);

    // Stuck-at-0: only the 16 vectors with (a+b) mod 16 == 0 pass
    mode = 2'd1;
    sweep1("stuck");
    chk("stuck_err",  32'(err1),  32'd240);
    chk("stuck_pass", 32'(pass1), 32'd0);
`ifdef TESTER_FIRST_FAIL_EN
    chk("stuck_fail", 32'(fail1), 32'h010);
`else
    chk("stuck_fail", 32'(fail1), 32'h000);
`endif

    // Inverted sum: every vector fails, count saturates
    mode = 2'd2;
    sweep1("inv");
    chk("inv_err",  32'(err1),  32'd255);
    chk("inv_pass", 32'(pass1), 32'd0);
`ifdef TESTER_FIRST_FAIL_EN
    chk("inv_fail", 32'(fail1), 32'h00F);
`else
    chk("inv_fail", 32'(fail1), 32'h000);
`endif

    // Three-cycle adder against a LATENCY=1 tester must report errors
    mode = 2'd3;
    sweep1("slow");
    chk("slow_err_nz", 32'(err1 != 8'd0), 32'd1);

    // Reset mid-sweep with errors already accumulated
    mode = 2'd1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (99) @(posedge clk);
    #1 chk("mid_err_nz", 32'(err1 != 8'd0), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_op",   32'({op_a1, op_b1}), 32'd0);
    chk("arst_err",  32'(err1),  32'd0);
    chk("arst_done", 32'(done1 | pass1), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", 32'({busy1, done1}), 32'd0);
    mode = 2'd0;
    sweep1("clean");
    chk("clean_pass", 32'(pass1), 32'd1);

    // start held high: done lasts one cycle, then a new sweep begins
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk);
    repeat (768) @(posedge clk);
    #1 chk("hold_done", 32'(done1), 32'd1);
    chk("hold_pass", 32'(pass1), 32'd1);
    @(posedge clk);
    #1 chk("hold_done_1cyc", 32'(done1), 32'd0);
    chk("hold_rebusy", 32'(busy1), 32'd1);
    start1 = 1'b0;
    repeat (770) @(posedge clk);
    #1 chk("hold_end_pass", 32'(pass1), 32'd1);

    // LATENCY=3 tester with matching three-cycle adder
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    repeat (1279) @(posedge clk);
    #1 chk("l3_done_early", 32'(done3), 32'd0);
    chk("l3_busy", 32'(busy3), 32'd1);
    @(posedge clk);
    #1 chk("l3_done", 32'(done3), 32'd1);
    chk("l3_pass", 32'(pass3), 32'd1);
    chk("l3_err",  32'(err3),  32'd0);
    chk("l3_fail", 32'(fail3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
